// File: rtl/random_16bit_gen.sv
// rtl/random_16bit_gen.sv - free-running 16-bit maximal-length Fibonacci LFSR
// Taps x^16 + x^14 + x^13 + x^11 + 1. A zero state reloads the seed, so the
// register cannot stay locked up.
module random_16bit_gen #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rand_num
);

    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] EFF_SEED = (SEED != 16'h0000) ? SEED : 16'h0001;

    logic [15:0] s;
    logic        fb;

    assign fb = s[15] ^ s[13] ^ s[12] ^ s[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= EFF_SEED;
        end else if (s == 16'h0000) begin
            s <= EFF_SEED;
        end else begin
            s <= {s[14:0], fb};
        end
    end

    assign rand_num = s;

endmodule

// File: tb/tb_random_16bit_gen.sv
// tb/tb_random_16bit_gen.sv - directed self-checking bench for random_16bit_gen
// Covers reset, first steps, full period wrap, mid-run reset, lock-up and seed handling.
module tb_random_16bit_gen;

    logic        clk;
    logic        rst_n;
    logic [15:0] rand_num;
    logic [15:0] rand_num_s1;
    logic [15:0] rand_num_s0;

    int checks_total;
    int checks_passed;

    random_16bit_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rand_num (rand_num)
    );

    random_16bit_gen #(.SEED(16'h0001)) dut_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rand_num (rand_num_s1)
    );

    random_16bit_gen #(.SEED(16'h0000)) dut_s0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rand_num (rand_num_s0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    bit          seen [65536];
    int          dups;
    int          zeros;
    logic [15:0] exp_v;
    logic [15:0] exp_1;
    logic [15:0] first_steps [3];

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        dups          = 0;
        zeros         = 0;
        first_steps[0] = 16'h59C3;
        first_steps[1] = 16'hB387;
        first_steps[2] = 16'h670F;
        rst_n = 1'b1;

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", rand_num, 16'hACE1);
        check("reset_seed1", rand_num_s1, 16'h0001);
        check("reset_seed0", rand_num_s0, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", rand_num, 16'hACE1);
        end

        // Release between edges; no effect until next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_noedge", rand_num, 16'hACE1);

        // Full period from release, with first steps and seed-1/seed-0 tracking
        exp_v = 16'hACE1;
        exp_1 = 16'h0001;
        seen[16'hACE1] = 1'b1;
        for (int n = 1; n <= 65536; n++) begin
            @(posedge clk);
            #1;
            exp_v = lfsr_step(exp_v);
            exp_1 = lfsr_step(exp_1);
            if (n <= 3) begin
                check("first_steps", rand_num, first_steps[n-1]);
            end
            if (n == 1) begin
                check("seed1_step1", rand_num_s1, 16'h0002);
                check("seed0_step1", rand_num_s0, 16'h0002);
            end
            if (n <= 32) begin
                check("seed1_seq", rand_num_s1, exp_1);
                check("seed0_seq", rand_num_s0, exp_1);
            end
            check("period_seq", rand_num, exp_v);
            if (n < 65535) begin
                if (rand_num == 16'h0000) zeros++;
                if (seen[rand_num]) dups++;
                seen[rand_num] = 1'b1;
            end
            if (n == 65535) check("wrap_seed", rand_num, 16'hACE1);
            if (n == 65536) check("wrap_step1", rand_num, 16'h59C3);
        end
        check("period_dups", dups[15:0], 16'd0);
        check("period_zeros", zeros[15:0], 16'd0);

        // Run on, then a short asynchronous reset pulse
        repeat (1000) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset", rand_num, 16'hACE1);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrun_release", rand_num, 16'hACE1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midrun_steps", rand_num, first_steps[i]);
        end

        // Lock-up recovery from a forced zero state
        @(negedge clk);
        force dut.s = 16'h0000;
        #1;
        check("lockup_forced", rand_num, 16'h0000);
        release dut.s;
        @(posedge clk);
        #1;
        check("lockup_reload", rand_num, 16'hACE1);
        @(posedge clk);
        #1;
        check("lockup_continue", rand_num, 16'h59C3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
